// File: rtl/sc_player_row_register_if.sv
// Bundle between the player movement FSM and the row register:
// shift/clear/hit commands in, one-hot row position and status out.
interface sc_player_row_register_if #(
   parameter int DATAWIDTH     = 8,
   parameter int MOVECNT_WIDTH = 8
);
   logic [1:0]               shift_sel_in;
   logic                     clear_in;
   logic                     hit_in;
   logic [DATAWIDTH-1:0]     row_out;
   logic                     at_left_edge_out;
   logic                     at_right_edge_out;
   logic                     frozen_out;
   logic [MOVECNT_WIDTH-1:0] move_count_out;

   modport master (
      output shift_sel_in, clear_in, hit_in,
      input  row_out, at_left_edge_out, at_right_edge_out, frozen_out, move_count_out
   );

   modport slave (
      input  shift_sel_in, clear_in, hit_in,
      output row_out, at_left_edge_out, at_right_edge_out, frozen_out, move_count_out
   );
endinterface

// File: rtl/sc_player_row_register.sv
// One-hot player position in the frog row with saturating single-bit moves,
// a collision freeze window and a counter of moves that changed position.
module sc_player_row_register #(
   parameter int DATAWIDTH     = 8,
   parameter int INIT_POS      = 3,
   parameter int FREEZE_CYCLES = 4,
   parameter int MOVECNT_WIDTH = 8
) (
   input logic                    SC_PLAYER_STATEMACHINE_CLOCK_50,
   input logic                    SC_PLAYER_STATEMACHINE_RESET_InHigh,
   sc_player_row_register_if.slave bus
);

   localparam int CNT_W = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] FREEZE_LOAD = CNT_W'(FREEZE_CYCLES - 1);
   localparam logic [DATAWIDTH-1:0] ROW_INIT = {{(DATAWIDTH-1){1'b0}}, 1'b1} << INIT_POS;

   typedef enum logic {
      ACTIVE = 1'b0,
      FROZEN = 1'b1
   } state_t;

   state_t                   r_state;
   logic [DATAWIDTH-1:0]     r_row;
   logic [CNT_W-1:0]         r_freezeCnt;
   logic [MOVECNT_WIDTH-1:0] r_moveCount;

   // Clear beats everything; a hit while active wins over a same-cycle shift.
   always_ff @(posedge SC_PLAYER_STATEMACHINE_CLOCK_50 or posedge SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
      if (SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
         r_state     <= ACTIVE;
         r_row       <= ROW_INIT;
         r_freezeCnt <= '0;
         r_moveCount <= '0;
      end else if (bus.clear_in) begin
         r_state     <= ACTIVE;
         r_row       <= ROW_INIT;
         r_freezeCnt <= '0;
         r_moveCount <= '0;
      end else begin
         case (r_state)
            ACTIVE: begin
               if (bus.hit_in) begin
                  r_state     <= FROZEN;
                  r_freezeCnt <= FREEZE_LOAD;
               end else if (bus.shift_sel_in == 2'b01 && !r_row[DATAWIDTH-1]) begin
                  r_row       <= r_row << 1;
                  r_moveCount <= r_moveCount + MOVECNT_WIDTH'(1);
               end else if (bus.shift_sel_in == 2'b10 && !r_row[0]) begin
                  r_row       <= r_row >> 1;
                  r_moveCount <= r_moveCount + MOVECNT_WIDTH'(1);
               end
            end
            FROZEN: begin
               // Further hits are ignored so the window is never stretched.
               if (r_freezeCnt == '0) begin
                  r_state <= ACTIVE;
               end else begin
                  r_freezeCnt <= r_freezeCnt - CNT_W'(1);
               end
            end
            default: r_state <= ACTIVE;
         endcase
      end
   end

   assign bus.row_out           = r_row;
   assign bus.at_left_edge_out  = r_row[DATAWIDTH-1];
   assign bus.at_right_edge_out = r_row[0];
   assign bus.frozen_out        = (r_state == FROZEN);
   assign bus.move_count_out    = r_moveCount;

endmodule

// File: tb/tb_sc_player_row_register.sv
// Directed bench for the player row register: a position/freeze/count model
// is checked every cycle, alongside hand-computed expectations.
module tb_sc_player_row_register;

   localparam int DW      = 8;
   localparam int INITPOS = 3;
   localparam int FREEZE  = 4;
   localparam int CW      = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int checks = 0;
   int errors = 0;
   bit compareEn = 1'b0;

   int modelPos;
   int modelFrozenLeft;
   int modelCount;

   sc_player_row_register_if #(.DATAWIDTH(DW), .MOVECNT_WIDTH(CW)) bus ();

   sc_player_row_register #(
      .DATAWIDTH(DW),
      .INIT_POS(INITPOS),
      .FREEZE_CYCLES(FREEZE),
      .MOVECNT_WIDTH(CW)
   ) dut (
      .SC_PLAYER_STATEMACHINE_CLOCK_50(clock),
      .SC_PLAYER_STATEMACHINE_RESET_InHigh(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   // Model tracks the position as an index and the freeze as cycles remaining.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         modelPos        = INITPOS;
         modelFrozenLeft = 0;
         modelCount      = 0;
      end else if (bus.clear_in) begin
         modelPos        = INITPOS;
         modelFrozenLeft = 0;
         modelCount      = 0;
      end else if (modelFrozenLeft > 0) begin
         modelFrozenLeft = modelFrozenLeft - 1;
      end else if (bus.hit_in) begin
         modelFrozenLeft = FREEZE;
      end else if (bus.shift_sel_in == 2'b01 && modelPos < DW - 1) begin
         modelPos   = modelPos + 1;
         modelCount = (modelCount + 1) % (1 << CW);
      end else if (bus.shift_sel_in == 2'b10 && modelPos > 0) begin
         modelPos   = modelPos - 1;
         modelCount = (modelCount + 1) % (1 << CW);
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (compareEn) begin
         checkOutput("cmp_row", longint'(bus.row_out), longint'(1) << modelPos);
         checkOutput("cmp_left", longint'(bus.at_left_edge_out), longint'(modelPos == DW - 1));
         checkOutput("cmp_right", longint'(bus.at_right_edge_out), longint'(modelPos == 0));
         checkOutput("cmp_frozen", longint'(bus.frozen_out), longint'(modelFrozenLeft > 0));
         checkOutput("cmp_count", longint'(bus.move_count_out), longint'(modelCount));
      end
   end

   task automatic applyStimulus(input logic [1:0] sel, input logic clr, input logic hit);
      bus.shift_sel_in = sel;
      bus.clear_in     = clr;
      bus.hit_in       = hit;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [7:0] leftRows [6];
      leftRows = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h80, 8'h80};

      bus.shift_sel_in = 2'b00;
      bus.clear_in     = 1'b0;
      bus.hit_in       = 1'b0;
      reset            = 1'b1;
      #23;
      reset = 1'b0;
      compareEn = 1'b1;

      // Test 1: reset defaults
      applyStimulus(2'b00, 1'b0, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("t1_row", longint'(bus.row_out), 64'h08);
      checkOutput("t1_left", longint'(bus.at_left_edge_out), 0);
      checkOutput("t1_right", longint'(bus.at_right_edge_out), 0);
      checkOutput("t1_frozen", longint'(bus.frozen_out), 0);
      checkOutput("t1_count", longint'(bus.move_count_out), 0);

      // Test 2: walk left into the MSB edge
      for (int i = 0; i < 6; i++) begin
         applyStimulus(2'b01, 1'b0, 1'b0);
         checkOutput("t2_row", longint'(bus.row_out), longint'(leftRows[i]));
         checkOutput("t2_left", longint'(bus.at_left_edge_out), longint'(i >= 3));
      end
      checkOutput("t2_count", longint'(bus.move_count_out), 4);

      // Test 3: walk right into the LSB edge
      applyStimulus(2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(2'b10, 1'b0, 1'b0);
         if (i == 2) checkOutput("t3_row_at3", longint'(bus.row_out), 64'h01);
      end
      checkOutput("t3_row", longint'(bus.row_out), 64'h01);
      checkOutput("t3_right", longint'(bus.at_right_edge_out), 1);
      checkOutput("t3_count", longint'(bus.move_count_out), 3);

      // Test 4: hit with same-cycle shift, repeated hit inside the window
      applyStimulus(2'b00, 1'b1, 1'b0);
      applyStimulus(2'b01, 1'b0, 1'b1);
      checkOutput("t4_row_hit", longint'(bus.row_out), 64'h08);
      checkOutput("t4_frozen_1", longint'(bus.frozen_out), 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b01, 1'b0, (i == 0));
         checkOutput("t4_frozen_n", longint'(bus.frozen_out), 1);
         checkOutput("t4_row_frozen", longint'(bus.row_out), 64'h08);
      end
      applyStimulus(2'b01, 1'b0, 1'b0);
      checkOutput("t4_frozen_drop", longint'(bus.frozen_out), 0);
      checkOutput("t4_row_drop", longint'(bus.row_out), 64'h08);
      applyStimulus(2'b01, 1'b0, 1'b0);
      checkOutput("t4_row_move", longint'(bus.row_out), 64'h10);
      checkOutput("t4_count", longint'(bus.move_count_out), 1);

      // Test 5: clear outranks hit and shift
      applyStimulus(2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b0, 1'b0);
      checkOutput("t5_row_pre", longint'(bus.row_out), 64'h40);
      checkOutput("t5_count_pre", longint'(bus.move_count_out), 3);
      applyStimulus(2'b10, 1'b1, 1'b1);
      checkOutput("t5_row", longint'(bus.row_out), 64'h08);
      checkOutput("t5_count", longint'(bus.move_count_out), 0);
      checkOutput("t5_frozen", longint'(bus.frozen_out), 0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("t5_frozen_after", longint'(bus.frozen_out), 0);

      // Test 6: asynchronous reset in the middle of a freeze window
      applyStimulus(2'b01, 1'b0, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("t6_frozen_pre", longint'(bus.frozen_out), 1);
      checkOutput("t6_row_pre", longint'(bus.row_out), 64'h10);
      reset = 1'b1;
      #1;
      checkOutput("t6_row_async", longint'(bus.row_out), 64'h08);
      checkOutput("t6_frozen_async", longint'(bus.frozen_out), 0);
      checkOutput("t6_count_async", longint'(bus.move_count_out), 0);
      #1;
      reset = 1'b0;
      applyStimulus(2'b01, 1'b0, 1'b0);
      checkOutput("t6_row_move", longint'(bus.row_out), 64'h10);
      applyStimulus(2'b00, 1'b0, 1'b0);

      compareEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_player_row_register.md
Name: sc_player_row_register

Overview:
Downstream consumer of the player movement state machine's 2-bit shift selection. It holds the player's horizontal position in the frog row as a one-hot register. Each cycle it applies at most one single-bit move and saturates at the row edges. A collision input triggers a freeze window during which moves are ignored. Its outputs feed the row/matrix composition logic, edge indicators and a move counter for scoring.

Parameters:
DATAWIDTH, 8, row width in bits; one-hot position register width; minimum 2.
INIT_POS, 3, bit index loaded on reset/clear; 0 <= INIT_POS < DATAWIDTH.
FREEZE_CYCLES, 4, number of cycles frozen_out stays high after an accepted hit; minimum 1.
MOVECNT_WIDTH, 8, width of the successful-move counter.

Ports:
SC_PLAYER_STATEMACHINE_CLOCK_50  in  1  system clock, rising edge.
SC_PLAYER_STATEMACHINE_RESET_InHigh  in  1  reset, asynchronous, active-high.
shift_sel_in  in  2  00 hold, 01 move left (toward MSB), 10 move right (toward LSB), 11 treated as hold.
clear_in  in  1  synchronous re-center/restart, active-high.
hit_in  in  1  collision strobe, active-high, sampled every cycle.
row_out  out  DATAWIDTH  registered one-hot player position.
at_left_edge_out  out  1  row_out[DATAWIDTH-1].
at_right_edge_out  out  1  row_out[0].
frozen_out  out  1  high while in FROZEN state.
move_count_out  out  MOVECNT_WIDTH  count of moves that actually changed position.

Behaviour:
- Reset (async, any time, including mid-freeze):
  - row_out = 1<<INIT_POS.
  - state = ACTIVE; frozen_out = 0.
  - freeze counter = 0; move_count_out = 0.
  - Edge outputs follow row_out.
- All updates happen on the rising clock edge. Inputs sampled at edge t take effect in the outputs after edge t (1-cycle latency).
- State machine has two states, ACTIVE and FROZEN.
- Priority each cycle: clear_in > hit_in (ACTIVE only) > shift_sel_in.
- clear_in = 1, any state:
  - row = 1<<INIT_POS; state = ACTIVE; freeze counter = 0; move_count = 0.
  - hit_in and shift_sel_in are ignored that cycle.
- ACTIVE, hit_in = 1:
  - Go to FROZEN; freeze counter loaded with FREEZE_CYCLES-1.
  - Row unchanged; a shift in the same cycle is dropped.
- ACTIVE, no hit, shift_sel_in = 01:
  - If row[DATAWIDTH-1] = 0: row <<= 1 and move_count increments.
  - Otherwise row is held and the count is unchanged (saturate, no wrap).
- ACTIVE, no hit, shift_sel_in = 10:
  - If row[0] = 0: row >>= 1 and move_count increments.
  - Otherwise row is held and the count is unchanged.
- ACTIVE, shift_sel_in = 00 or 11: hold.
- FROZEN:
  - All shift_sel_in values are ignored; row is held.
  - hit_in is ignored; it does not restart the window.
  - If counter = 0, next state = ACTIVE; otherwise counter decrements.
  - frozen_out is high for exactly FREEZE_CYCLES consecutive cycles after the edge that accepted the hit.
  - A shift presented on the first cycle after frozen_out drops is accepted.
- move_count wraps modulo 2^MOVECNT_WIDTH; it is a plain counter, not saturating.
- row_out is always exactly one-hot. Illegal encodings (e.g. after an SEU) are not corrected except by reset or clear.
- The upstream FSM emits single-cycle 01/10 pulses per button press. This block moves once per cycle that the code is present and needs no edge detection.

Test Plan:
1. Reset, then idle (defaults) -> row_out=0x08, edges 0/0, frozen_out=0, move_count_out=0.
2. shift_sel_in=01 for 6 consecutive cycles from 0x08 -> row 0x10,0x20,0x40,0x80,0x80,0x80; at_left_edge_out=1 from 4th cycle; move_count_out=4.
3. shift_sel_in=10 for 9 consecutive cycles from 0x08 -> row reaches 0x01 after 3 cycles and holds; at_right_edge_out=1; move_count_out=3.
4. hit_in=1 with shift_sel_in=01 same cycle, then 01 every cycle -> row stays 0x08, frozen_out high exactly 4 cycles; second hit_in during freeze does not extend it; first move 0x10 appears on the edge after frozen_out falls.
5. After several moves (row 0x40, count 3), pulse clear_in together with hit_in and shift 10 -> row 0x08, count 0, frozen_out=0.
6. Assert reset mid-freeze (cycle 2 of 4) -> frozen_out=0, row_out=0x08 immediately without a clock edge; after release, shift 01 moves to 0x10 on next edge.
